// File: rtl/filt_pkg.sv
// Shared encodings for the filter stimulus generator.
// FILT_STIM_PRBS_EN replaces the RAMP mode code with a 7-bit PRBS.
package filt_pkg;

    localparam int unsigned X_W_DEF  = 7;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned LFSR_W   = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

`ifdef FILT_STIM_PRBS_EN
    typedef enum logic [MODE_W-1:0] {
        MODE_STEP    = 2'd0,
        MODE_IMPULSE = 2'd1,
        MODE_SQUARE  = 2'd2,
        MODE_PRBS    = 2'd3
    } mode_e;
`else
    typedef enum logic [MODE_W-1:0] {
        MODE_STEP    = 2'd0,
        MODE_IMPULSE = 2'd1,
        MODE_SQUARE  = 2'd2,
        MODE_RAMP    = 2'd3
    } mode_e;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/filter_stim_gen_smp_strobe_gen.sv
// Phase accumulator: carry-out strobe and free-running MSB sample clock.
module smp_strobe_gen #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [ACC_W-1:0] fcw,
    output logic             strobe_c,
    output logic             smp_clk
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum_c;

    assign sum_c    = {1'b0, acc} + {1'b0, fcw};
    assign strobe_c = sum_c[ACC_W];
    assign smp_clk  = acc[ACC_W-1];

    // Accumulator advances every clock; a run start realigns the phase to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else begin
            acc <= sum_c[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/filter_stim_gen.sv
// Test waveform source for the FIR filter x_n input (STEP/IMPULSE/SQUARE/RAMP).
// Define FILT_STIM_PRBS_EN to turn mode 3 into a 7-bit PRBS instead of RAMP.
module filter_stim_gen
    import filt_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned X_W   = X_W_DEF,
    parameter int unsigned LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ACC_W-1:0]        fcw,
    input  logic [MODE_W-1:0]       mode,
    input  logic signed [X_W-1:0]   amp,
    input  logic [LEN_W-1:0]        half_per,
    input  logic [LEN_W-1:0]        len,
    input  logic                    start,
    input  logic                    stop,
    output logic signed [X_W-1:0]   x_n,
    output logic                    x_valid,
    output logic                    smp_clk,
    output logic                    busy,
    output logic                    done
);

    localparam logic [X_W-1:0] X_MIN = {1'b1, {(X_W-1){1'b0}}};
    localparam logic [X_W-1:0] X_MAX = {1'b0, {(X_W-1){1'b1}}};

    state_e                 state, next_state;
    mode_e                  mode_q;
    logic signed [X_W-1:0]  amp_q;
    logic [LEN_W-1:0]       hp_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       count_q;
    logic [LEN_W-1:0]       ph_q;
    logic                   pol_q;
    logic                   strobe_c;
    logic                   load_c;
    logic                   emit_c;
    logic signed [X_W-1:0]  amp_neg_c;
    logic signed [X_W-1:0]  sample_c;
`ifdef FILT_STIM_PRBS_EN
    logic [LFSR_W-1:0]      lfsr_q;
`endif

    smp_strobe_gen #(.ACC_W(ACC_W)) u_strobe (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_c),
        .fcw      (fcw),
        .strobe_c (strobe_c),
        .smp_clk  (smp_clk)
    );

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == ST_RUN);
            done  <= (next_state == ST_DONE);
        end
    end

    // Next state and control; stop beats start in IDLE and beats a strobe in RUN.
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        emit_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    next_state = ST_RUN;
                    load_c     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop || ((len_q != '0) && (count_q == len_q))) begin
                    next_state = ST_DONE;
                end else if (strobe_c) begin
                    emit_c = 1'b1;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Next sample value from the latched configuration.
    always_comb begin
        amp_neg_c = (amp_q == X_MIN) ? X_MAX : -amp_q;
        sample_c  = amp_q;
        case (mode_q)
            MODE_STEP:    sample_c = amp_q;
            MODE_IMPULSE: sample_c = (count_q == '0) ? amp_q : '0;
            MODE_SQUARE:  sample_c = pol_q ? amp_neg_c : amp_q;
`ifdef FILT_STIM_PRBS_EN
            MODE_PRBS:    sample_c = X_W'(lfsr_q);
`else
            MODE_RAMP:    sample_c = (count_q == '0) ? amp_q : x_n + X_W'(1);
`endif
            default:      sample_c = amp_q;
        endcase
    end

    // Config latch, sample counter, square phase and output sample register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_STEP;
            amp_q   <= '0;
            hp_q    <= LEN_W'(1);
            len_q   <= '0;
            count_q <= '0;
            ph_q    <= '0;
            pol_q   <= 1'b0;
            x_n     <= '0;
            x_valid <= 1'b0;
`ifdef FILT_STIM_PRBS_EN
            lfsr_q  <= LFSR_SEED;
`endif
        end else begin
            x_valid <= 1'b0;
            if (load_c) begin
                mode_q  <= mode_e'(mode);
                amp_q   <= amp;
                hp_q    <= (half_per == '0) ? LEN_W'(1) : half_per;
                len_q   <= len;
                count_q <= '0;
                ph_q    <= '0;
                pol_q   <= 1'b0;
                x_n     <= '0;
`ifdef FILT_STIM_PRBS_EN
                lfsr_q  <= LFSR_SEED;
`endif
            end else if (emit_c) begin
                x_n     <= sample_c;
                x_valid <= 1'b1;
                count_q <= count_q + LEN_W'(1);
                if (ph_q + LEN_W'(1) >= hp_q) begin
                    ph_q  <= '0;
                    pol_q <= ~pol_q;
                end else begin
                    ph_q  <= ph_q + LEN_W'(1);
                end
`ifdef FILT_STIM_PRBS_EN
                lfsr_q  <= {lfsr_q[LFSR_W-2:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
            end
        end
    end

endmodule

// File: tb/tb_filter_stim_gen.sv
// Directed bench for filter_stim_gen with hand-computed sample sequences.
module tb_filter_stim_gen;

    logic               clk = 1'b0;
    logic               reset;
    logic [15:0]        fcw;
    logic [1:0]         mode;
    logic signed [6:0]  amp;
    logic [15:0]        half_per;
    logic [15:0]        len;
    logic               start;
    logic               stop;
    logic signed [6:0]  x_n;
    logic               x_valid;
    logic               smp_clk;
    logic               busy;
    logic               done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    filter_stim_gen dut (
        .clk      (clk),
        .reset    (reset),
        .fcw      (fcw),
        .mode     (mode),
        .amp      (amp),
        .half_per (half_per),
        .len      (len),
        .start    (start),
        .stop     (stop),
        .x_n      (x_n),
        .x_valid  (x_valid),
        .smp_clk  (smp_clk),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input int a, input int hp, input int l);
        @(negedge clk);
        mode     = m;
        amp      = 7'(a);
        half_per = 16'(hp);
        len      = 16'(l);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int v, output bit ok);
        ok = 1'b0;
        v  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (x_valid) begin
                v  = int'(x_n);
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Collect n samples against the expected list, then check the done pulse.
    task automatic expect_run(input string tag, input int exp[$]);
        int v;
        bit ok;
        foreach (exp[i]) begin
            wait_valid(40, v, ok);
            if (!ok) begin
                check($sformatf("%s_timeout%0d", tag, i), 0, 1);
                return;
            end
            check($sformatf("%s_x%0d", tag, i), v, exp[i]);
        end
        @(negedge clk);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_hold"}, int'(x_n), exp[exp.size()-1]);
    endtask

    initial begin
        int v, v0, t_prev, highs, seen;
        bit ok;
        int exp_q[$];
        logic [6:0] lf;

        reset = 1'b1; fcw = 16'h0100; mode = 2'd0; amp = '0;
        half_per = '0; len = '0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x_n", int'(x_n), 0);
        check("rst_x_valid", int'(x_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_smp_clk", int'(smp_clk), 0);
        reset = 1'b0;

        // STEP, len=0, strobe every 256 clocks
        do_start(2'd0, 1, 0, 0);
        check("step_busy", int'(busy), 1);
        wait_valid(300, v, ok);
        check("step_first", ok ? v : -99, 1);
        t_prev = cyc;
        for (int k = 0; k < 2; k++) begin
            highs = 0; ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (x_valid) begin ok = 1'b1; break; end
                if (smp_clk) highs++;
            end
            check($sformatf("step_period%0d", k), ok ? cyc - t_prev : -1, 256);
            check($sformatf("step_x%0d", k), int'(x_n), 1);
            check($sformatf("step_smpclk_high%0d", k), highs, 128);
            t_prev = cyc;
        end
        check("step_busy_run", int'(busy), 1);
        check("step_no_done", int'(done), 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("step_stop_done", int'(done), 1);
        check("step_stop_busy", int'(busy), 0);

        fcw = 16'h4000;

        // IMPULSE; the following start must zero x_n without x_valid
        do_start(2'd1, 5, 0, 8);
        exp_q = '{5, 0, 0, 0, 0, 0, 0, 0};
        expect_run("imp", exp_q);

        do_start(2'd2, 3, 2, 8);
        check("start_clears_x", int'(x_n), 0);
        check("start_no_valid", int'(x_valid), 0);
        exp_q = '{3, 3, -3, -3, 3, 3, -3, -3};
        expect_run("sq", exp_q);

        do_start(2'd2, -64, 2, 4);
        exp_q = '{-64, -64, 63, 63};
        expect_run("sqsat", exp_q);

        // half_per=0 behaves as 1
        do_start(2'd2, 7, 0, 4);
        exp_q = '{7, -7, 7, -7};
        expect_run("sqhp0", exp_q);

`ifdef FILT_STIM_PRBS_EN
        exp_q = {};
        lf = 7'h01;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(int'($signed(lf)));
            lf = {lf[5:0], lf[6] ^ lf[5]};
        end
        do_start(2'd3, 62, 0, 6);
        expect_run("prbs", exp_q);
`else
        lf = 7'h00;
        do_start(2'd3, 62, 0, 4);
        exp_q = '{62, 63, -64, -63};
        expect_run("ramp", exp_q);
`endif

        // stop after the 3rd of 10 samples
        do_start(2'd0, 9, 0, 10);
        for (int i = 0; i < 3; i++) begin
            wait_valid(40, v, ok);
            check($sformatf("stop_x%0d", i), ok ? v : -99, 9);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_done", int'(done), 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (x_valid) seen++;
        end
        check("stop_no_more_valid", seen, 0);
        check("stop_idle_busy", int'(busy), 0);

        // start+stop together in IDLE
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("ss_idle_busy", int'(busy), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (x_valid || busy || done) seen++;
        end
        check("ss_idle_quiet", seen, 0);

        // fcw=0: run never progresses, then reset mid-run
        fcw = 16'h0000;
        do_start(2'd0, 4, 0, 3);
        seen = 0; v0 = 0;
        repeat (300) begin
            @(negedge clk);
            if (x_valid) seen++;
            if (smp_clk) v0++;
        end
        check("fcw0_no_valid", seen, 0);
        check("fcw0_smpclk_const", v0, 0);
        check("fcw0_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstrun_busy", int'(busy), 0);
        check("rstrun_done", int'(done), 0);

        // reset with a nonzero sample on x_n
        fcw = 16'h4000;
        do_start(2'd0, 11, 0, 0);
        wait_valid(40, v, ok);
        check("rst2_pre", ok ? v : -99, 11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_x_n", int'(x_n), 0);
        check("rst2_busy", int'(busy), 0);
        @(negedge clk);
        check("rst2_no_done", int'(done), 0);
        check("rst2_x_valid", int'(x_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
